// File: rtl/uart_loader.sv
// Parses framed program-load bytes from the UART RX FIFO into 32-bit memory writes, then acks.
// Latency: mem_we one cycle after a word's 4th byte; ack pushed one cycle after tx_ready seen.
// Backpressure: rx_avail=0 stalls parsing; tx_ready=0 holds the frame in ACK with busy high.
module uart_loader #(
    parameter int                    ADDR_WIDTH = 17,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [7:0]            HEADER     = 8'hA5,
    parameter logic [7:0]            ACK_OK     = 8'h5A,
    parameter logic [7:0]            ACK_ERR    = 8'hEE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_avail,
    input  logic [7:0]            rx_data,
    output logic                  rx_pop,
    input  logic                  tx_ready,
    output logic                  tx_push,
    output logic [7:0]            tx_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_ACK
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           widx_q, widx_d;
    logic [1:0]            bidx_q, bidx_d;
    logic [23:0]           word_q, word_d;
    logic [7:0]            chk_q, chk_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  tx_push_q, tx_push_d;
    logic [7:0]            tx_data_q, tx_data_d;

    // Every state except ACK consumes bytes; reset forces the strobe low.
    assign rx_pop = rst && rx_avail && (state_q != S_ACK);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        widx_d      = widx_q;
        bidx_d      = bidx_q;
        word_d      = word_q;
        chk_d       = chk_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        tx_push_d   = 1'b0;
        tx_data_d   = tx_data_q;
        case (state_q)
            S_IDLE: begin
                if (rx_pop && rx_data == HEADER) begin
                    state_d = S_LEN0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    chk_d   = 8'h00;
                    widx_d  = 16'h0000;
                    bidx_d  = 2'd0;
                end
            end
            S_LEN0: begin
                if (rx_pop) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (rx_pop) begin
                    len_d[15:8] = rx_data;
                    state_d     = ({rx_data, len_q[7:0]} != 16'h0000) ? S_DATA : S_CHK;
                end
            end
            S_DATA: begin
                if (rx_pop) begin
                    chk_d  = chk_q ^ rx_data;
                    bidx_d = bidx_q + 2'd1;
                    case (bidx_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        default: begin
                            // Address wraps modulo the port width by construction.
                            mem_we_d    = 1'b1;
                            mem_wdata_d = {rx_data, word_q};
                            mem_addr_d  = BASE_ADDR + ADDR_WIDTH'(widx_q);
                            widx_d      = widx_q + 16'd1;
                            if (widx_q == len_q - 16'd1) begin
                                state_d = S_CHK;
                            end
                        end
                    endcase
                end
            end
            S_CHK: begin
                if (rx_pop) begin
                    error_d = (rx_data != chk_q);
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (tx_ready) begin
                    tx_push_d = 1'b1;
                    tx_data_d = error_q ? ACK_ERR : ACK_OK;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            len_q       <= 16'h0000;
            widx_q      <= 16'h0000;
            bidx_q      <= 2'd0;
            word_q      <= 24'h000000;
            chk_q       <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            tx_push_q   <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            widx_q      <= widx_d;
            bidx_q      <= bidx_d;
            word_q      <= word_d;
            chk_q       <= chk_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            tx_push_q   <= tx_push_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign tx_push   = tx_push_q;
    assign tx_data   = tx_data_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: two instances (default base, and a 4-bit address at base 15 for wrap)
// share one RX byte stream; a frame-level model predicts every memory write and ack byte.
module tb_uart_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_avail;
    logic [7:0]  rx_data;
    logic        tx_ready;

    logic        d1_rx_pop, d1_tx_push, d1_mem_we, d1_busy, d1_done, d1_error;
    logic [7:0]  d1_tx_data;
    logic [16:0] d1_mem_addr;
    logic [31:0] d1_mem_wdata;
    logic        d2_rx_pop, d2_tx_push, d2_mem_we, d2_busy, d2_done, d2_error;
    logic [7:0]  d2_tx_data;
    logic [3:0]  d2_mem_addr;
    logic [31:0] d2_mem_wdata;

    always #5 clk = ~clk;

    uart_loader #(.ADDR_WIDTH(17), .BASE_ADDR(17'd0)) u_dut1 (
        .clk(clk), .rst(rst), .rx_avail(rx_avail), .rx_data(rx_data), .rx_pop(d1_rx_pop),
        .tx_ready(tx_ready), .tx_push(d1_tx_push), .tx_data(d1_tx_data),
        .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata),
        .busy(d1_busy), .done(d1_done), .error(d1_error)
    );

    uart_loader #(.ADDR_WIDTH(4), .BASE_ADDR(4'd15)) u_dut2 (
        .clk(clk), .rst(rst), .rx_avail(rx_avail), .rx_data(rx_data), .rx_pop(d2_rx_pop),
        .tx_ready(tx_ready), .tx_push(d2_tx_push), .tx_data(d2_tx_data),
        .mem_we(d2_mem_we), .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata),
        .busy(d2_busy), .done(d2_done), .error(d2_error)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  stream[$];
    logic [15:0] e1_idx[$], e2_idx[$];
    logic [31:0] e1_dat[$], e2_dat[$];
    logic [7:0]  a1[$], a2[$];
    int          wr1 = 0, push1 = 0;
    bit          gate_toggle = 1'b0;
    bit          gate = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level model: walk the byte list, skip non-header bytes, emit words and the ack byte.
    task automatic model(input logic [7:0] b[$]);
        int         i = 0;
        int         n;
        logic [7:0] x;
        logic [31:0] w;
        while (i < b.size()) begin
            if (b[i] != 8'hA5) begin
                i++;
                continue;
            end
            n = int'(b[i+1]) + 256 * int'(b[i+2]);
            i += 3;
            x = 8'h00;
            for (int k = 0; k < n; k++) begin
                w = {b[i+3], b[i+2], b[i+1], b[i]};
                x = x ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
                e1_idx.push_back(16'(k)); e1_dat.push_back(w);
                e2_idx.push_back(16'(k)); e2_dat.push_back(w);
                i += 4;
            end
            a1.push_back((b[i] == x) ? 8'h5A : 8'hEE);
            a2.push_back((b[i] == x) ? 8'h5A : 8'hEE);
            i++;
        end
    endtask

    task automatic send(input logic [7:0] b[$]);
        model(b);
        foreach (b[k]) stream.push_back(b[k]);
    endtask

    task automatic wait_idle(input string name, input int max);
        int c = 0;
        while (!(stream.size() == 0 && a1.size() == 0 && a2.size() == 0) && c < max) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(c >= max), 32'd0);
        repeat (2) @(negedge clk);
        check({name, " writes drained"}, 32'(e1_dat.size() + e2_dat.size()), 32'd0);
    endtask

    // RX FIFO model: head byte valid when non-empty (optionally gated every other cycle).
    initial begin : drv
        bit pop_now;
        rx_avail = 1'b0;
        rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            pop_now = d1_rx_pop;
            @(posedge clk);
            if (pop_now && stream.size() > 0) void'(stream.pop_front());
            #1;
            gate     = gate_toggle ? ~gate : 1'b1;
            rx_avail = gate && (stream.size() > 0);
            rx_data  = (stream.size() > 0) ? stream[0] : 8'h00;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (d1_mem_we) begin
                wr1++;
                if (e1_dat.size() == 0) check("d1 unexpected mem_we", 32'd1, 32'd0);
                else begin
                    check("d1 mem_addr", 32'(d1_mem_addr), 32'(e1_idx[0]));
                    check("d1 mem_wdata", d1_mem_wdata, e1_dat[0]);
                    void'(e1_idx.pop_front()); void'(e1_dat.pop_front());
                end
            end
            if (d2_mem_we) begin
                if (e2_dat.size() == 0) check("d2 unexpected mem_we", 32'd1, 32'd0);
                else begin
                    check("d2 mem_addr", 32'(d2_mem_addr), 32'((15 + int'(e2_idx[0])) % 16));
                    check("d2 mem_wdata", d2_mem_wdata, e2_dat[0]);
                    void'(e2_idx.pop_front()); void'(e2_dat.pop_front());
                end
            end
            if (d1_tx_push) begin
                push1++;
                if (a1.size() == 0) check("d1 unexpected tx_push", 32'd1, 32'd0);
                else check("d1 tx_data", 32'(d1_tx_data), 32'(a1.pop_front()));
            end
            if (d2_tx_push) begin
                if (a2.size() == 0) check("d2 unexpected tx_push", 32'd1, 32'd0);
                else check("d2 tx_data", 32'(d2_tx_data), 32'(a2.pop_front()));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [7:0] good[$], bad[$], garb[$], hdr_in_data[$], three[$];
        int p1, w0, c;
        good = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        bad  = good;
        bad[bad.size()-1] = 8'h00;
        garb = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        hdr_in_data = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
        three = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                  8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0C};
        rst = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset mem_we", 32'(d1_mem_we), 32'd0);
        check("reset tx_push", 32'(d1_tx_push), 32'd0);
        check("reset mem_addr", 32'(d1_mem_addr), 32'd0);
        check("reset mem_wdata", d1_mem_wdata, 32'd0);
        check("reset busy/done/error", 32'({d1_busy, d1_done, d1_error}), 32'd0);
        check("reset tx_data", 32'(d1_tx_data), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        send(good);
        check("model word0", e1_dat[0], 32'h4433_2211);
        check("model word1", e1_dat[1], 32'h8877_6655);
        check("model ack good", 32'(a1[0]), 32'h5A);
        w0 = wr1;
        wait_idle("good frame", 200);
        check("good writes", 32'(wr1 - w0), 32'd2);
        check("good done/error/busy", 32'({d1_done, d1_error, d1_busy}), 32'b100);
        check("good tx_data", 32'(d1_tx_data), 32'h5A);
        check("good last addr", 32'(d1_mem_addr), 32'd1);
        check("good last wdata", d1_mem_wdata, 32'h8877_6655);
        check("wrap second word addr", 32'(d2_mem_addr), 32'd0);

        send(bad);
        wait_idle("bad checksum", 200);
        check("bad done/error/busy", 32'({d1_done, d1_error, d1_busy}), 32'b110);
        check("bad tx_data", 32'(d1_tx_data), 32'hEE);

        w0 = wr1;
        send(garb);
        wait_idle("empty frame", 200);
        check("empty no writes", 32'(wr1 - w0), 32'd0);
        check("empty done/error", 32'({d1_done, d1_error}), 32'b10);
        check("empty tx_data", 32'(d1_tx_data), 32'h5A);

        send(hdr_in_data);
        wait_idle("header in data", 200);
        check("header in data wdata", d1_mem_wdata, 32'hA5A5_A5A5);

        gate_toggle = 1'b1;
        w0 = wr1;
        send(good);
        wait_idle("rx stall", 400);
        gate_toggle = 1'b0;
        check("stall writes", 32'(wr1 - w0), 32'd2);
        check("stall last wdata", d1_mem_wdata, 32'h8877_6655);

        tx_ready = 1'b0;
        p1 = push1;
        send(good);
        c = 0;
        while (stream.size() != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("backpressure drain", 32'(c >= 200), 32'd0);
        repeat (20) @(negedge clk);
        check("backpressure busy", 32'(d1_busy), 32'd1);
        check("backpressure done", 32'(d1_done), 32'd0);
        check("backpressure no push", 32'(push1 - p1), 32'd0);
        tx_ready = 1'b1;
        wait_idle("backpressure release", 50);
        check("backpressure one push", 32'(push1 - p1), 32'd1);
        check("backpressure busy clear", 32'(d1_busy), 32'd0);

        w0 = wr1;
        send(three);
        c = 0;
        while (wr1 < w0 + 1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("mid-frame first write", 32'(c >= 200), 32'd0);
        #1;
        rst = 1'b0;
        stream.delete();
        e1_idx.delete(); e1_dat.delete(); e2_idx.delete(); e2_dat.delete();
        a1.delete(); a2.delete();
        #1;
        check("mid reset rx_pop", 32'(d1_rx_pop), 32'd0);
        check("mid reset mem_we", 32'(d1_mem_we), 32'd0);
        check("mid reset outputs", {d1_mem_wdata[15:0], 15'(d1_mem_addr), d1_busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("no write after reset", 32'(wr1 - w0), 32'd1);
        send(good);
        wait_idle("after reset", 200);
        check("after reset addr", 32'(d1_mem_addr), 32'd1);
        check("after reset done", 32'({d1_done, d1_error}), 32'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
